// File: rtl/dot_accumulator.sv
// Dot-product accumulator behind the SIMD MAC adder tree: sums cfg_len_i partial sums,
// rounds/shifts/saturates each result and buffers it in a 2-entry valid/ready queue.
module dot_accumulator #(
   parameter int SUM_W   = 20,
   parameter int MAX_LEN = 256,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int ACC_W   = SUM_W + $clog2(MAX_LEN),
   parameter int OUT_W   = 16,
   parameter int SHIFT_W = $clog2(ACC_W)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sum_valid_i,
   input  logic signed [SUM_W-1:0]    sum_i,
   input  logic        [LEN_W-1:0]    cfg_len_i,
   input  logic        [SHIFT_W-1:0]  cfg_shift_i,
   input  logic                       flush_i,
   output logic                       result_valid_o,
   input  logic                       result_ready_i,
   output logic signed [OUT_W-1:0]    result_o,
   output logic                       result_sat_o,
   output logic                       busy_o,
   output logic                       drop_err_o
);

   localparam int OUT_MAX_I = 2 ** (OUT_W - 1) - 1;
   localparam int OUT_MIN_I = -(2 ** (OUT_W - 1));
   localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W + 1)'(OUT_MAX_I);
   localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W + 1)'(OUT_MIN_I);

   logic        [LEN_W-1:0]   cnt;
   logic        [LEN_W-1:0]   len_q;
   logic        [LEN_W-1:0]   cfg_len_clamped;
   logic        [LEN_W-1:0]   cur_len;
   logic        [SHIFT_W-1:0] shift_q;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   sum_ext;
   logic                      accept;
   logic                      first_beat;
   logic                      last_beat;
   logic                      done_q;

   logic signed [ACC_W:0]     acc_ext;
   logic signed [ACC_W:0]     rnd;
   logic signed [ACC_W:0]     shifted;
   logic        [OUT_W-1:0]   pp_next;
   logic                      pp_next_sat;
   logic                      pp_valid;
   logic        [OUT_W-1:0]   pp_data;
   logic                      pp_sat;

   logic        [OUT_W-1:0]   q_data [2];
   logic                      q_sat  [2];
   logic                      rd_ptr;
   logic                      wr_ptr;
   logic        [1:0]         q_count;
   logic                      q_pop;
   logic                      q_push;
   logic                      q_full;

   // The length of a group is only known on its first beat, so the compare uses the live config then.
   always_comb begin
      cfg_len_clamped = cfg_len_i;
      if (cfg_len_i == '0) begin
         cfg_len_clamped = LEN_W'(1);
      end else if (cfg_len_i > LEN_W'(MAX_LEN)) begin
         cfg_len_clamped = LEN_W'(MAX_LEN);
      end
      accept     = sum_valid_i && !flush_i;
      first_beat = (cnt == '0);
      cur_len    = first_beat ? cfg_len_clamped : len_q;
      last_beat  = accept && ((cnt + LEN_W'(1)) == cur_len);
      sum_ext    = {{(ACC_W - SUM_W){sum_i[SUM_W-1]}}, sum_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         len_q   <= LEN_W'(1);
         shift_q <= '0;
         acc     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last_beat;
         if (flush_i) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= last_beat ? '0 : cnt + LEN_W'(1);
            if (first_beat) begin
               len_q   <= cfg_len_clamped;
               shift_q <= cfg_shift_i;
               acc     <= sum_ext;
            end else begin
               acc <= acc + sum_ext;
            end
         end
      end
   end

   // One extra bit of headroom keeps the round-half-up add from overflowing.
   always_comb begin
      acc_ext     = {acc[ACC_W-1], acc};
      rnd         = '0;
      shifted     = acc_ext;
      if (shift_q != '0) begin
         rnd     = (ACC_W + 1)'(1) << (shift_q - SHIFT_W'(1));
         shifted = (acc_ext + rnd) >>> shift_q;
      end
      pp_next     = shifted[OUT_W-1:0];
      pp_next_sat = 1'b0;
      if (shifted > OUT_MAX) begin
         pp_next     = OUT_MAX[OUT_W-1:0];
         pp_next_sat = 1'b1;
      end else if (shifted < OUT_MIN) begin
         pp_next     = OUT_MIN[OUT_W-1:0];
         pp_next_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pp_valid <= 1'b0;
         pp_data  <= '0;
         pp_sat   <= 1'b0;
      end else begin
         pp_valid <= done_q;
         pp_data  <= pp_next;
         pp_sat   <= pp_next_sat;
      end
   end

   // A full queue still takes a push when the head leaves in the same cycle.
   always_comb begin
      q_pop  = (q_count != 2'd0) && result_ready_i;
      q_full = (q_count == 2'd2);
      q_push = pp_valid && (!q_full || q_pop);
      wr_ptr = rd_ptr ^ q_count[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= 1'b0;
         q_count    <= 2'd0;
         drop_err_o <= 1'b0;
      end else begin
         if (q_push) begin
            q_data[wr_ptr] <= pp_data;
            q_sat[wr_ptr]  <= pp_sat;
         end
         if (q_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({q_push, q_pop})
            2'b10:   q_count <= q_count + 2'd1;
            2'b01:   q_count <= q_count - 2'd1;
            default: q_count <= q_count;
         endcase
         if (pp_valid && q_full && !q_pop) begin
            drop_err_o <= 1'b1;
         end
      end
   end

   always_comb begin
      result_valid_o = (q_count != 2'd0);
      result_o       = result_valid_o ? q_data[rd_ptr] : '0;
      result_sat_o   = result_valid_o ? q_sat[rd_ptr] : 1'b0;
      busy_o         = (cnt != '0);
   end

endmodule

// File: tb/tb_dot_accumulator.sv
// Scoreboard bench for dot_accumulator: a group/queue-level reference model predicts
// results, occupancy, busy and drop flag; a negedge monitor compares against the DUT.
module tb_dot_accumulator;

   localparam int SUM_W   = 20;
   localparam int MAX_LEN = 256;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int ACC_W   = SUM_W + $clog2(MAX_LEN);
   localparam int OUT_W   = 16;
   localparam int SHIFT_W = $clog2(ACC_W);

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      sum_valid_i;
   logic signed [SUM_W-1:0]   sum_i;
   logic        [LEN_W-1:0]   cfg_len_i;
   logic        [SHIFT_W-1:0] cfg_shift_i;
   logic                      flush_i;
   logic                      result_valid_o;
   logic                      result_ready_i;
   logic signed [OUT_W-1:0]   result_o;
   logic                      result_sat_o;
   logic                      busy_o;
   logic                      drop_err_o;

   dot_accumulator #(
      .SUM_W(SUM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
      .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
   ) dut (
      .clk(clk), .rst(rst), .sum_valid_i(sum_valid_i), .sum_i(sum_i),
      .cfg_len_i(cfg_len_i), .cfg_shift_i(cfg_shift_i), .flush_i(flush_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_o(result_o), .result_sat_o(result_sat_o),
      .busy_o(busy_o), .drop_err_o(drop_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint val;
      bit     sat;
      int     due;
   } res_t;

   res_t   pending[$];
   res_t   exp_q[$];
   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   int     occ      = 0;
   bit     m_drop   = 1'b0;
   int     g_cnt    = 0;
   int     g_len    = 1;
   int     g_shift  = 0;
   longint g_acc    = 0;

   task automatic checkOutput(input string name, input logic signed [63:0] actual,
                              input logic signed [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   function automatic res_t postProcess(input longint acc, input int sh);
      res_t   r;
      longint v;
      longint div;
      v = acc;
      if (sh > 0) begin
         div = longint'(1) << sh;
         v   = acc + div / 2;
         // floor division, so negative halves round toward +inf
         v   = (v >= 0) ? v / div : -((-v + div - 1) / div);
      end
      r.sat = 1'b0;
      if (v > 32767) begin
         v     = 32767;
         r.sat = 1'b1;
      end else if (v < -32768) begin
         v     = -32768;
         r.sat = 1'b1;
      end
      r.val = v;
      r.due = 0;
      return r;
   endfunction

   // Reference model: group sums, two-cycle result latency, 2-deep queue with drop on overflow.
   always @(posedge clk) begin : model
      bit   pop;
      res_t item;
      int   l;
      cyc++;
      if (rst) begin
         pending.delete();
         exp_q.delete();
         occ    = 0;
         m_drop = 1'b0;
         g_cnt  = 0;
      end else begin
         pop = (occ > 0) && result_ready_i;
         if (pending.size() > 0 && pending[0].due == cyc) begin
            item = pending.pop_front();
            if (occ < 2 || pop) begin
               exp_q.push_back(item);
               occ++;
            end else begin
               m_drop = 1'b1;
            end
         end
         if (pop) occ--;
         if (flush_i) begin
            g_cnt = 0;
         end else if (sum_valid_i) begin
            if (g_cnt == 0) begin
               l       = int'(cfg_len_i);
               g_len   = (l == 0) ? 1 : ((l > MAX_LEN) ? MAX_LEN : l);
               g_shift = int'(cfg_shift_i);
               g_acc   = 0;
            end
            g_acc += longint'(sum_i);
            g_cnt++;
            if (g_cnt == g_len) begin
               item     = postProcess(g_acc, g_shift);
               item.due = cyc + 2;
               pending.push_back(item);
               g_cnt = 0;
            end
         end
      end
   end

   // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
   always @(negedge clk) begin : monitor
      res_t item;
      checkOutput("result_valid", result_valid_o, occ > 0);
      checkOutput("busy", busy_o, g_cnt != 0);
      checkOutput("drop_err", drop_err_o, m_drop);
      if (result_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result: got %0d expected none at cycle %0d", result_o, cyc);
         end else begin
            item = exp_q[0];
            checkOutput("result", result_o, item.val);
            checkOutput("result_sat", result_sat_o, item.sat);
            if (result_ready_i) void'(exp_q.pop_front());
         end
      end else begin
         checkOutput("idle_result", result_o, 0);
         checkOutput("idle_sat", result_sat_o, 0);
      end
   end

   task automatic applyStimulus(input bit v, input int s, input int len, input int sh, input bit fl);
      @(posedge clk);
      #1;
      sum_valid_i = v;
      sum_i       = SUM_W'(s);
      cfg_len_i   = LEN_W'(len);
      cfg_shift_i = SHIFT_W'(sh);
      flush_i     = fl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic pulseReset();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      rst = 1'b1;
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      rst = 1'b0;
   endtask

   logic signed [SUM_W-1:0] rnd_sum;
   int                      rnd_len;
   int                      rnd_s;

   initial begin
      rst            = 1'b1;
      sum_valid_i    = 1'b0;
      sum_i          = '0;
      cfg_len_i      = '0;
      cfg_shift_i    = '0;
      flush_i        = 1'b0;
      result_ready_i = 1'b0;
      idle(2);
      rst            = 1'b0;
      result_ready_i = 1'b1;

      // basic group, shift 0
      applyStimulus(1'b1, 100, 4, 0, 1'b0);
      applyStimulus(1'b1, -20, 4, 0, 1'b0);
      applyStimulus(1'b1, 7, 4, 0, 1'b0);
      applyStimulus(1'b1, 13, 4, 0, 1'b0);
      idle(4);

      // rounding with gaps
      foreach (rnd_sum[i]) ;
      applyStimulus(1'b1, 5, 3, 2, 1'b0);
      idle(1);
      applyStimulus(1'b1, 5, 0, 0, 1'b0);
      idle(2);
      applyStimulus(1'b1, 6, 0, 0, 1'b0);
      idle(1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, -3, 3, 2, 1'b0);
         idle(1);
      end
      idle(3);

      // full-length saturation both ways
      for (int i = 0; i < 256; i++) applyStimulus(1'b1, 524287, 256, 0, 1'b0);
      idle(3);
      for (int i = 0; i < 256; i++) applyStimulus(1'b1, -524288, 256, 0, 1'b0);
      idle(4);

      // overflow of the queue with no consumer
      result_ready_i = 1'b0;
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, i, 1, 0, 1'b0);
      idle(3);
      result_ready_i = 1'b1;
      idle(4);
      pulseReset();

      // flush mid-group with a concurrent beat
      applyStimulus(1'b1, 10, 4, 0, 1'b0);
      applyStimulus(1'b1, 10, 4, 0, 1'b0);
      applyStimulus(1'b1, 99, 4, 0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1, 4, 0, 1'b0);
      idle(4);

      // reset with results queued and a partial group
      result_ready_i = 1'b0;
      applyStimulus(1'b1, 11, 1, 0, 1'b0);
      applyStimulus(1'b1, 12, 1, 0, 1'b0);
      applyStimulus(1'b1, 5, 4, 0, 1'b0);
      applyStimulus(1'b1, 6, 4, 0, 1'b0);
      idle(3);
      pulseReset();
      result_ready_i = 1'b1;
      applyStimulus(1'b1, 3, 2, 0, 1'b0);
      applyStimulus(1'b1, 4, 2, 0, 1'b0);
      idle(4);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rnd_sum = SUM_W'($urandom);
         rnd_s   = ($urandom_range(0, 1) == 0) ? int'(rnd_sum) : $urandom_range(0, 200) - 100;
         rnd_len = $urandom_range(0, 19);
         rnd_len = (rnd_len == 0) ? 0 : ((rnd_len == 1) ? $urandom_range(200, 511) : $urandom_range(1, 6));
         result_ready_i = ($urandom_range(0, 3) != 0);
         applyStimulus($urandom_range(0, 3) != 0, rnd_s, rnd_len,
                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, ACC_W - 1),
                       $urandom_range(0, 40) == 0);
      end

      // drain with a bounded wait
      result_ready_i = 1'b1;
      idle(1);
      for (int i = 0; i < 20 && (exp_q.size() != 0 || pending.size() != 0); i++) idle(1);
      checks++;
      if (exp_q.size() != 0 || pending.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d results outstanding expected 0", exp_q.size() + pending.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Sits directly downstream of the SIMD vector MAC adder tree and consumes its sum/valid stream.
- Accumulates cfg_len_i consecutive tree sums into one dot-product result.
- Post-processes each result: round, arithmetic right shift, saturate to OUT_W.
- Buffers results in a 2-entry output queue with valid/ready. The adder tree has no backpressure, so a result that arrives when the queue is full is dropped and flagged.

Parameters:
- SUM_W, 20, width of signed input partial sum (ELEM_W 16 + clog2(16)).
- MAX_LEN, 256, maximum number of partial sums per dot product.
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len_i.
- ACC_W, SUM_W+$clog2(MAX_LEN), accumulator width; sized so accumulation cannot wrap.
- OUT_W, 16, signed output result width.
- SHIFT_W, $clog2(ACC_W), width of cfg_shift_i.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sum_valid_i  in  1  partial sum valid (tree sum_valid_o).
- sum_i  in  SUM_W  signed partial sum (tree sum_o).
- cfg_len_i  in  LEN_W  sums per dot product; sampled on first beat of each group.
- cfg_shift_i  in  SHIFT_W  right-shift amount; sampled on first beat of each group.
- flush_i  in  1  abort the in-progress group.
- result_valid_o  out  1  queue head valid.
- result_ready_i  in  1  consumer accepts head when high with result_valid_o.
- result_o  out  OUT_W  signed, rounded, saturated result at queue head.
- result_sat_o  out  1  head result was saturated.
- busy_o  out  1  a group is partially accumulated (beat count != 0).
- drop_err_o  out  1  sticky: a completed result was discarded because the queue was full.

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - beat counter, accumulator and post-process stage valid;
  - both queue entries;
  - drop_err_o.
  - All outputs read 0 in the cycle after reset. Reset mid-group discards the group; reset with results queued discards them.
- Group accounting:
  - cnt counts accepted beats. A beat is accepted when sum_valid_i=1 and flush_i=0.
  - On a beat with cnt==0: latch len_q = max(cfg_len_i, 1) and shift_q = cfg_shift_i; acc <= sext(sum_i).
  - On a beat with cnt!=0: acc <= acc + sext(sum_i).
  - The beat where cnt+1 == len_q is the last beat: cnt <= 0 and done pulses.
  - cfg_len_i=0 is treated as 1. Values above MAX_LEN are clamped to MAX_LEN.
  - sum_valid_i=0 cycles are ignored (gaps are allowed mid-group).
- flush_i=1:
  - cnt <= 0 and the partial accumulator is discarded.
  - A beat presented in the same cycle is discarded too.
  - The post-process stage and the queue are unaffected.
- Post-process (one register stage, input = final acc value and shift_q):
  - If shift_q>0: r = (acc + (1 << (shift_q-1))) >>> shift_q (round half up). If shift_q==0: r = acc.
  - Internal width is ACC_W+1, so the rounding add cannot overflow.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 if clamped.
- Latency: last beat sampled at edge t -> acc final at t+1 -> result enters queue at t+2. result_valid_o=1 from the cycle after edge t+2 if the queue was empty.
- Queue: 2-entry FIFO, head drives result_o/result_sat_o. Pop when result_valid_o & result_ready_i.
  - Push and pop in the same cycle while full: the push is accepted.
  - Push while full without pop: the result is dropped and drop_err_o <= 1 (sticky until rst). Queue contents are unchanged.
  - Push and pop in the same cycle while holding 1 entry: the new entry becomes head next cycle.
  - Back-to-back groups (len=1, valid every cycle) produce one result per cycle at full throughput while ready is held high.
- result_o/result_sat_o are 0 when the queue is empty.
- busy_o = (cnt != 0).

Test Plan:
- len=4, shift=0, sums 100, -20, 7, 13 on consecutive cycles, ready=1 -> result_o=100 exactly 2 cycles after the 4th beat; sat=0; single valid pulse.
- len=3, shift=2, sums 5, 5, 6 with idle gaps between beats -> acc 16, (16+2)>>>2 = 4. Then sums -3, -3, -3 -> (-9+2)>>>2 = -2.
- len=256, shift=0, 256 beats of sum_i=2^19-1 -> result_o=32767, result_sat_o=1. Repeat with -2^19 -> -32768, sat=1.
- len=1, valid every cycle, sums 1..6, ready=0 -> only results 1 and 2 queued; drop_err_o=1 from the 3rd completion. Assert ready -> 1 then 2 popped, then result_valid_o=0.
- len=4: two beats (10, 10), then flush_i with a concurrent beat 99, then four beats of 1 -> single result 4; busy_o=0 after the flush.
- rst asserted with 2 results queued and a group half accumulated -> next cycle all outputs 0. A following len=2 group of 3, 4 -> 7.
